// File: rtl/ram_dp_if.sv
// Bus bundle for the dual-port RAM: read/write port A, read-only port B and the busy flag.
// The master drives requests; the RAM (slave) returns read data, valid strobes and busy.
interface ram_dp_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  localparam int BE = DATA_WIDTH / 8;

  logic                  busy;
  logic                  a_en;
  logic                  a_we;
  logic [BE-1:0]         a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;
  logic                  b_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;

  modport master (
    input  busy, a_rdata, a_rvalid, b_rdata, b_rvalid,
    output a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr
  );

  modport slave (
    output busy, a_rdata, a_rvalid, b_rdata, b_rvalid,
    input  a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr
  );
endinterface

// File: rtl/ram_dp.sv
// Dual-port synchronous RAM: port A read/write with byte enables, port B read-only,
// selectable read-during-write policy, 1/2-cycle output pipeline and post-reset clear.
module ram_dp #(
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    WRITE_FIRST    = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic    clk,
  input  logic    rst,
  ram_dp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BE    = DATA_WIDTH / 8;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("ram_dp: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("ram_dp: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_reg;
  logic                  busy_reg;
  logic [ADDR_WIDTH-1:0] clr_addr_reg;

  // busy falls on the same edge that writes the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy_reg     <= (CLEAR_ON_RESET != 0);
      clr_addr_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_addr_reg <= clr_addr_reg + 1'b1;
      if (clr_addr_reg == {ADDR_WIDTH{1'b1}}) begin
        state_reg <= READY;
        busy_reg  <= 1'b0;
      end
    end
  end

  assign bus.busy = busy_reg;

  logic                  clearing;
  logic                  a_acc;
  logic                  b_acc;
  logic                  a_wr;
  logic                  b_hit;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [BE-1:0]         w_be;

  always_comb begin
    clearing = (state_reg == CLEAR) && !rst;
    a_acc    = bus.a_en && !busy_reg && !rst;
    b_acc    = bus.b_en && !busy_reg && !rst;
    a_wr     = a_acc && bus.a_we;
    b_hit    = a_wr && (bus.b_addr == bus.a_addr);
    // the sequencer and port A never write in the same cycle, so one write port suffices
    w_en     = clearing || a_wr;
    w_addr   = clearing ? clr_addr_reg : bus.a_addr;
    w_data   = clearing ? CLEAR_VALUE : bus.a_wdata;
    w_be     = clearing ? {BE{1'b1}} : bus.a_be;
  end

  logic [DATA_WIDTH-1:0] a_s0_data;
  logic [DATA_WIDTH-1:0] b_s0_data;
  logic                  a_s0_valid_reg;
  logic                  b_s0_valid_reg;

  // One byte-wide array per lane keeps byte writes a plain per-lane write enable.
  generate
    for (genvar gi = 0; gi < BE; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] a_lane_reg;
      logic [7:0] b_lane_reg;
      logic       a_fwd;
      logic       b_fwd;

      assign a_fwd = (WRITE_FIRST != 0) && a_wr && bus.a_be[gi];
      assign b_fwd = (WRITE_FIRST != 0) && b_hit && bus.a_be[gi];

      always_ff @(posedge clk) begin
        if (w_en && w_be[gi]) begin
          mem[w_addr] <= w_data[8*gi +: 8];
        end
      end

      // Read-first returns the array word; write-first bypasses the enabled new byte.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_lane_reg <= '0;
          b_lane_reg <= '0;
        end else begin
          if (a_acc) begin
            a_lane_reg <= a_fwd ? bus.a_wdata[8*gi +: 8] : mem[bus.a_addr];
          end
          if (b_acc) begin
            b_lane_reg <= b_fwd ? bus.a_wdata[8*gi +: 8] : mem[bus.b_addr];
          end
        end
      end

      assign a_s0_data[8*gi +: 8] = a_lane_reg;
      assign b_s0_data[8*gi +: 8] = b_lane_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s0_valid_reg <= 1'b0;
      b_s0_valid_reg <= 1'b0;
    end else begin
      a_s0_valid_reg <= a_acc;
      b_s0_valid_reg <= b_acc;
    end
  end

  logic [DATA_WIDTH-1:0] out_data [2];
  logic                  out_valid [2];

  // Output pipeline per port (0 = A, 1 = B); data only advances with its valid bit,
  // so the last stage holds the previous read while idle.
  generate
    for (genvar gp = 0; gp < 2; gp++) begin : g_port
      logic [DATA_WIDTH-1:0] in_data;
      logic                  in_valid;
      logic [DATA_WIDTH-1:0] data_reg [READ_LATENCY];
      logic                  valid_reg [READ_LATENCY];

      assign in_data  = (gp == 0) ? a_s0_data : b_s0_data;
      assign in_valid = (gp == 0) ? a_s0_valid_reg : b_s0_valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < READ_LATENCY; k++) begin
            data_reg[k]  <= '0;
            valid_reg[k] <= 1'b0;
          end
        end else begin
          valid_reg[0] <= in_valid;
          if (in_valid) begin
            data_reg[0] <= in_data;
          end
          for (int k = 1; k < READ_LATENCY; k++) begin
            valid_reg[k] <= valid_reg[k-1];
            if (valid_reg[k-1]) begin
              data_reg[k] <= data_reg[k-1];
            end
          end
        end
      end

      assign out_data[gp]  = data_reg[READ_LATENCY-1];
      assign out_valid[gp] = valid_reg[READ_LATENCY-1];
    end
  endgenerate

  assign bus.a_rdata  = out_data[0];
  assign bus.a_rvalid = out_valid[0];
  assign bus.b_rdata  = out_data[1];
  assign bus.b_rvalid = out_valid[1];
endmodule
